// File: rtl/arith_pkg.sv
// Shared encodings for the multi-precision add/subtract sequencer.
// Sequencer states, operation codes and the unit byte width.
package arith_pkg;

  localparam int DBW = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ADJ,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/addsubUnit.sv
// Byte add/subtract unit: binary result combinational, decimal
// adjust computed from the operands captured when rdy is high.
module addsubUnit
  import arith_pkg::*;
#(
  parameter int DBW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  input  logic           op,
  input  logic           dec,
  input  logic           ci,
  input  logic [DBW-1:0] a,
  input  logic [DBW-1:0] b,
  output logic [DBW-1:0] o,
  output logic           co,
  output logic           v,
  output logic [DBW-1:0] dadj,
  output logic           dco
);

  logic [DBW-1:0] bx;
  logic [DBW:0]   s;
  logic [DBW-1:0] a_r;
  logic [DBW-1:0] b_r;
  logic           ci_r;
  logic           op_r;
  logic           c_d;
  logic [4:0]     t_d;

  assign bx = (op == OP_SUB) ? ~b : b;
  assign s  = {1'b0, a} + {1'b0, bx} + {{DBW{1'b0}}, ci};
  assign o  = s[DBW-1:0];
  assign co = s[DBW];
  assign v  = (a[DBW-1] == bx[DBW-1]) && (o[DBW-1] != a[DBW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      ci_r <= 1'b0;
      op_r <= 1'b0;
    end else if (rdy) begin
      a_r  <= a;
      b_r  <= b;
      ci_r <= ci;
      op_r <= op;
    end
  end

  // Per-digit adjust; the unit ignores dec, the caller chooses
  // which output to take.
  always_comb begin
    dadj = '0;
    c_d  = ci_r;
    t_d  = '0;
    for (int k = 0; k < DBW / 4; k++) begin
      if (op_r == OP_ADD) begin
        t_d = {1'b0, a_r[4*k +: 4]} + {1'b0, b_r[4*k +: 4]}
            + {4'b0, c_d};
        if (t_d > 5'd9) begin
          t_d = t_d + 5'd6;
          c_d = 1'b1;
        end else begin
          c_d = 1'b0;
        end
      end else begin
        t_d = {1'b0, a_r[4*k +: 4]} - {1'b0, b_r[4*k +: 4]}
            - {4'b0, ~c_d};
        if (t_d[4]) begin
          t_d = t_d - 5'd6;
          c_d = 1'b0;
        end else begin
          c_d = 1'b1;
        end
      end
      dadj[4*k +: 4] = t_d[3:0];
    end
    dco = c_d;
  end

  logic unused_dec;
  assign unused_dec = dec;

endmodule

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract sequencer, LSB first, with
// 6502-style C/V/Z/N flags over the whole operand.
module addsub_seq
  import arith_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op,
  input  logic          dec,
  input  logic          ci,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          opr_req,
  output logic [LW-1:0] opr_idx,
  input  logic          opr_ack,
  input  logic [7:0]    opr_a,
  input  logic [7:0]    opr_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [LW-1:0] res_idx,
  output logic [7:0]    res_data,
  output logic          done,
  output logic          flag_c,
  output logic          flag_v,
  output logic          flag_z,
  output logic          flag_n
);

  state_t          state;
  state_t          nxt;
  logic [LW-1:0]   idx;
  logic [LW-1:0]   len_q;
  logic            op_q;
  logic            dec_q;
  logic            carry;
  logic            z_acc;
  logic            cout;
  logic            vout;
  logic [DBW-1:0]  opa;
  logic [DBW-1:0]  opb;
  logic [DBW-1:0]  rbyte;
  logic [DBW-1:0]  u_o;
  logic [DBW-1:0]  u_do;
  logic            u_co;
  logic            u_v;
  logic            u_dco;
  logic            last;

  assign last = (idx == len_q - LW'(1));

  addsubUnit #(
    .DBW (DBW)
  ) u_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (state == S_EXEC),
    .op    (op_q),
    .dec   (dec_q),
    .ci    (carry),
    .a     (opa),
    .b     (opb),
    .o     (u_o),
    .co    (u_co),
    .v     (u_v),
    .dadj  (u_do),
    .dco   (u_dco)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    busy      = 1'b1;
    opr_req   = 1'b0;
    opr_idx   = '0;
    res_valid = 1'b0;
    res_idx   = '0;
    res_data  = '0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          nxt = (len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        opr_req = 1'b1;
        opr_idx = idx;
        if (opr_ack) nxt = S_EXEC;
      end
      S_EXEC: nxt = dec_q ? S_ADJ : S_WRITE;
      S_ADJ:  nxt = S_WRITE;
      S_WRITE: begin
        res_valid = 1'b1;
        res_idx   = idx;
        res_data  = rbyte;
        if (res_ready) nxt = last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      len_q  <= '0;
      op_q   <= 1'b0;
      dec_q  <= 1'b0;
      carry  <= 1'b0;
      z_acc  <= 1'b0;
      cout   <= 1'b0;
      vout   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      rbyte  <= '0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            dec_q <= dec;
            carry <= ci;
            len_q <= len;
            idx   <= '0;
            z_acc <= 1'b1;
          end
        end
        S_FETCH: begin
          if (opr_ack) begin
            opa <= opr_a;
            opb <= opr_b;
          end
        end
        S_EXEC: begin
          if (!dec_q) begin
            rbyte <= u_o;
            cout  <= u_co;
            vout  <= u_v;
          end
        end
        S_ADJ: begin
          rbyte <= u_do;
          cout  <= u_dco;
          vout  <= u_v;
        end
        S_WRITE: begin
          if (res_ready) begin
            carry  <= cout;
            z_acc  <= z_acc & (rbyte == 8'h00);
            flag_n <= rbyte[7];
            flag_v <= vout;
            if (!last) idx <= idx + LW'(1);
          end
        end
        S_DONE: begin
          flag_c <= carry;
          flag_z <= z_acc;
          // Empty operation: no byte ever wrote V/N.
          if (len_q == '0) begin
            flag_v <= 1'b0;
            flag_n <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed table, corner sequences and
// random operations against an arithmetic reference model.
module tb_addsub_seq;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic          dec = 1'b0;
  logic          ci = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          opr_req;
  logic [LW-1:0] opr_idx;
  logic          opr_ack = 1'b0;
  logic [7:0]    opr_a = '0;
  logic [7:0]    opr_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [LW-1:0] res_idx;
  logic [7:0]    res_data;
  logic          done;
  logic          flag_c;
  logic          flag_v;
  logic          flag_z;
  logic          flag_n;

  addsub_seq #(.LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .dec       (dec),
    .ci        (ci),
    .len       (len),
    .busy      (busy),
    .opr_req   (opr_req),
    .opr_idx   (opr_idx),
    .opr_ack   (opr_ack),
    .opr_a     (opr_a),
    .opr_b     (opr_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .res_data  (res_data),
    .done      (done),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    bit          op;
    bit          dec;
    bit          ci;
    int          len;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    bit          c;
    bit          v;
    bit          z;
    bit          n;
    bit          chkv;
    int          lat;
    int          ackd;
    int          rdyd;
  } vec_t;

  function automatic longint bcd2int(input logic [63:0] x, input int nd);
    longint acc = 0;
    for (int i = nd - 1; i >= 0; i--)
      acc = acc * 10 + longint'(x[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [63:0] int2bcd(input longint x, input int nd);
    logic [63:0] r = '0;
    longint t = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Whole-number arithmetic: operands as unsigned/signed integers
  // or decimal values, never byte by byte.
  task automatic model(input bit mop, mdec, mci, input int ml,
                       input logic [63:0] A, B,
                       output logic [63:0] R,
                       output bit c, v, z, n);
    longint m, ua, ub, s, sa, sb, sr;
    int nb = 8 * ml;
    if (mdec) begin
      m  = 1;
      for (int i = 0; i < 2 * ml; i++) m = m * 10;
      ua = bcd2int(A, 2 * ml);
      ub = bcd2int(B, 2 * ml);
    end else begin
      m  = longint'(1) << nb;
      ua = longint'(A);
      ub = longint'(B);
    end
    s = mop ? ua - ub - longint'(!mci) : ua + ub + longint'(mci);
    c = mop ? (s >= 0) : (s >= m);
    s = ((s % m) + m) % m;
    R = mdec ? int2bcd(s, 2 * ml) : 64'(s);
    sa = (!mdec && ua >= m / 2) ? ua - m : ua;
    sb = (!mdec && ub >= m / 2) ? ub - m : ub;
    sr = mop ? sa - sb - longint'(!mci) : sa + sb + longint'(mci);
    v = (sr < -(m / 2)) || (sr >= m / 2);
    z = (R == 64'd0);
    n = R[nb-1];
  endtask

  task automatic run_op(input string nm, input bit op_i, dec_i, ci_i,
                        input int len_i, input logic [63:0] A, B,
                        input int ackd, rdyd, input bit poke,
                        input int rst_at,
                        output logic [63:0] R, output int lat);
    int cyc, wa, wr, nexp;
    bit ok, stable;
    logic [LW-1:0] hi_f, hi_r;
    logic [7:0] hd;
    R = '0; lat = -1; ok = 0; stable = 1;
    wa = 0; wr = 0; nexp = 0; hi_f = '0; hi_r = '0; hd = '0;
    op = op_i; dec = dec_i; ci = ci_i; len = LW'(len_i);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (cyc == rst_at) begin
        chk({nm, " busy_pre_rst"}, 64'(busy), 64'd1);
        chk({nm, " adj_idle_pre_rst"}, 64'({opr_req, res_valid}), 64'd0);
        rst_n = 1'b0;
        #1;
        chk({nm, " outs_in_rst"},
            64'({busy, opr_req, opr_idx, res_valid, res_idx, res_data,
                 done, flag_c, flag_v, flag_z, flag_n}), 64'd0);
        opr_ack = 1'b0;
        res_ready = 1'b0;
        return;
      end
      if (poke) begin
        start = (cyc == 3);
        len = (cyc == 3) ? '0 : LW'(len_i);
        op = (cyc == 3) ? !op_i : op_i;
      end
      if (done) begin
        lat = cyc;
        ok = 1;
        break;
      end
      opr_ack = 1'b0;
      res_ready = 1'b0;
      opr_a = 8'($urandom);
      opr_b = 8'($urandom);
      if (opr_req) begin
        if (wa == 0) hi_f = opr_idx;
        else if (opr_idx !== hi_f) stable = 0;
        if (wa < ackd) wa++;
        else begin
          if (int'(opr_idx) != nexp) stable = 0;
          opr_ack = 1'b1;
          opr_a = A[int'(opr_idx)*8 +: 8];
          opr_b = B[int'(opr_idx)*8 +: 8];
          wa = 0;
        end
      end
      if (res_valid) begin
        if (wr == 0) begin
          hi_r = res_idx;
          hd = res_data;
        end else if (res_idx !== hi_r || res_data !== hd) stable = 0;
        if (wr < rdyd) wr++;
        else begin
          if (int'(res_idx) != nexp) stable = 0;
          res_ready = 1'b1;
          R[int'(res_idx)*8 +: 8] = res_data;
          nexp++;
          wr = 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    opr_ack = 1'b0;
    res_ready = 1'b0;
    chk({nm, " done_seen"}, 64'(ok), 64'd1);
    chk({nm, " stable_order"}, 64'(stable), 64'd1);
    chk({nm, " bytes"}, 64'(nexp), 64'(len_i));
    if (ok) begin
      @(posedge clk); #1;
      chk({nm, " done_pulse"}, 64'({done, busy}), 64'd0);
    end
  endtask

  task automatic check_vec(input vec_t t, input bit poke);
    logic [63:0] R;
    int lat;
    run_op(t.nm, t.op, t.dec, t.ci, t.len, t.a, t.b,
           t.ackd, t.rdyd, poke, 0, R, lat);
    chk({t.nm, " result"}, R, t.r);
    chk({t.nm, " latency"}, 64'(lat), 64'(t.lat));
    chk({t.nm, " C"}, 64'(flag_c), 64'(t.c));
    chk({t.nm, " Z"}, 64'(flag_z), 64'(t.z));
    chk({t.nm, " N"}, 64'(flag_n), 64'(t.n));
    if (t.chkv) chk({t.nm, " V"}, 64'(flag_v), 64'(t.v));
  endtask

  initial begin
    vec_t tv[8];
    logic [63:0] R, er, ra, rb;
    int lat, rl, ad, rd;
    bit rop, rdec, rci, ec, ev, ez, en;

    tv[0] = '{"bin_add", 0, 0, 0, 2, 64'h12FF, 64'h0001, 64'h1300,
              0, 0, 0, 0, 1, 7, 0, 0};
    tv[1] = '{"bcd_add", 0, 1, 0, 2, 64'h9999, 64'h0001, 64'h0000,
              1, 0, 1, 0, 0, 9, 0, 0};
    tv[2] = '{"bcd_sub", 1, 1, 1, 2, 64'h0100, 64'h0001, 64'h0099,
              1, 0, 0, 0, 0, 9, 0, 0};
    tv[3] = '{"bin_sub", 1, 0, 1, 2, 64'h0000, 64'h0001, 64'hFFFF,
              0, 0, 0, 1, 1, 7, 0, 0};
    tv[4] = '{"bin_ovf", 0, 0, 0, 1, 64'h7F, 64'h01, 64'h80,
              0, 1, 0, 1, 1, 4, 0, 0};
    tv[5] = '{"len0", 0, 0, 1, 0, 64'h0, 64'h0, 64'h0,
              1, 0, 1, 0, 1, 1, 0, 0};
    tv[6] = '{"backpressure", 0, 0, 0, 1, 64'h12, 64'h34, 64'h46,
              0, 0, 0, 0, 1, 9, 2, 3};
    tv[7] = '{"add3_ovf", 0, 0, 0, 3, 64'h800000, 64'h800000, 64'h0,
              1, 1, 1, 0, 1, 10, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        64'({busy, opr_req, opr_idx, res_valid, res_idx, res_data,
             done, flag_c, flag_v, flag_z, flag_n}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) check_vec(tv[i], 1'b0);

    run_op("rst_in_adj", 0, 1, 0, 2, 64'h9999, 64'h0001, 0, 0, 0, 7,
           R, lat);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_vec(tv[4], 1'b0);

    check_vec(tv[0], 1'b1);

    for (int k = 0; k < 40; k++) begin
      rop = 1'($urandom);
      rdec = 1'($urandom);
      rci = 1'($urandom);
      rl = $urandom_range(1, 6);
      ad = $urandom_range(0, 2);
      rd = $urandom_range(0, 2);
      ra = '0;
      rb = '0;
      for (int d = 0; d < 2 * rl; d++) begin
        ra[4*d +: 4] = rdec ? 4'($urandom_range(0, 9)) : 4'($urandom);
        rb[4*d +: 4] = rdec ? 4'($urandom_range(0, 9)) : 4'($urandom);
      end
      model(rop, rdec, rci, rl, ra, rb, er, ec, ev, ez, en);
      run_op("rnd", rop, rdec, rci, rl, ra, rb, ad, rd, 0, 0, R, lat);
      chk("rnd result", R, er);
      chk("rnd latency", 64'(lat),
          64'(1 + rl * ((rdec ? 4 : 3) + ad + rd)));
      chk("rnd C", 64'(flag_c), 64'(ec));
      chk("rnd Z", 64'(flag_z), 64'(ez));
      chk("rnd N", 64'(flag_n), 64'(en));
      if (!rdec) chk("rnd V", 64'(flag_v), 64'(ev));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Multi-precision add/subtract sequencer around the existing 8-bit addsubUnit (DBW=8), instantiated inside this block.
- Walks an N-byte operand pair least-significant byte first, fetching one byte pair per step. It drives the unit, waits for the decimal adjust when in BCD mode, chains the carry, and streams result bytes out.
- Used by the core's multi-byte arithmetic helper (wide ADC/SBC).
- Returns 6502-style C/V/Z/N flags for the whole operation.

Parameters:
LW, 4, width of length and index fields (max 2^LW-1 bytes)

Ports:
clk      in   1   clock; all state on rising edge
rst_n    in   1   reset, asynchronous, active-low
start    in   1   begin operation; sampled only when busy=0
op       in   1   0=add, 1=subtract; latched on start
dec      in   1   1=BCD mode; latched on start
ci       in   1   initial carry (subtract: 1 = no borrow); latched on start
len      in   LW  byte count; latched on start
busy     out  1   operation in progress
opr_req  out  1   operand fetch request
opr_idx  out  LW  byte index requested (0 = LSB)
opr_ack  in   1   operand byte pair valid this cycle
opr_a    in   8   operand A byte
opr_b    in   8   operand B byte
res_valid out 1   result byte valid
res_ready in  1   consumer accepts result byte
res_idx  out  LW  index of result byte
res_data out  8   result byte
done     out  1   one-cycle completion pulse
flag_c   out  1   final carry (subtract: 1 = no borrow)
flag_v   out  1   overflow of most significant byte
flag_z   out  1   1 if every result byte was zero
flag_n   out  1   bit 7 of most significant result byte

Behaviour:
- Reset (async, any state): state=IDLE, idx=0. Carry, data and flag registers are 0; all outputs are 0.
- States: IDLE, FETCH, EXEC, ADJ, WRITE, DONE.
- IDLE: busy=0.
  - start=1 latches op, dec, ci, len.
  - Sets idx=0, z_acc=1, carry=ci.
  - Next state is FETCH, or DONE if len=0.
- FETCH: opr_req=1, opr_idx=idx, held until opr_ack. An ack in the same cycle as the request is legal. On ack, latch opr_a and opr_b, then go to EXEC.
- Unit drive, valid in EXEC and ADJ:
  - a, b, ci=carry, op, dec held stable for both cycles.
  - Unit rdy=1 in EXEC only, so its internal sum register loads once.
- EXEC:
  - dec=0: capture o, co, v into rbyte, cout, vout; go to WRITE.
  - dec=1: go to ADJ.
- ADJ (dec=1 only): capture do into rbyte, dco into cout, v into vout; go to WRITE.
- WRITE:
  - res_valid=1 with res_idx=idx and res_data=rbyte, held stable until res_ready.
  - On accept: carry<=cout; z_acc<=z_acc & (rbyte==0); flag_n<=rbyte[7]; flag_v<=vout.
  - If idx==len-1, go to DONE; otherwise idx<=idx+1 and go to FETCH.
- DONE:
  - done=1 for one cycle; flag_c<=carry; flag_z<=z_acc; busy=1; next state IDLE.
  - When len=0: flag_c=ci, flag_z=1, flag_v=0, flag_n=0.
- Flags are updated only in WRITE/DONE and hold until the next operation overwrites them.
- busy=1 in every state except IDLE. start while busy is ignored.
- Latency with zero-wait ack/ready: done is asserted 1+3*len cycles after the start cycle in binary mode, 1+4*len in BCD mode. Each wait cycle on ack or ready adds one cycle.
- BCD operands containing invalid digits (>9): result is whatever the unit produces; no error is flagged.
- A new start is accepted in the cycle after DONE.

Decomposition:
- Shared package arith_pkg: state encodings (3-bit, S_IDLE..S_DONE), OP_ADD=0, OP_SUB=1, byte width constant 8.
- No new sub-module; the single natural child is the existing addsubUnit instance.
- The FSM, index counter and flag accumulation live in addsub_seq.

Test Plan:
- Binary add, len=2, A=0x12FF, B=0x0001, ci=0 -> bytes 0x00 then 0x13; C=0 Z=0 N=0 V=0; done 7 cycles after start.
- BCD add, len=2, A=0x9999, B=0x0001, ci=0 -> bytes 0x00, 0x00; C=1 Z=1; done 9 cycles after start.
- BCD subtract, len=2, A=0x0100, B=0x0001, ci=1 -> bytes 0x99, 0x00; C=1 (no borrow); Z=0.
- Binary subtract, len=2, A=0x0000, B=0x0001, ci=1 -> 0xFF, 0xFF; C=0 N=1. Separately, len=1, 0x7F+0x01 -> 0x80, V=1 N=1.
- Backpressure: delay opr_ack 2 cycles and hold res_ready low 3 cycles. opr_req/opr_idx and res_valid/res_data/res_idx must stay stable throughout; done is delayed by 5 cycles.
- rst_n low during the ADJ state of byte 1 -> all outputs 0 immediately. len=0 start -> done next cycle with C=ci, Z=1. start pulsed while busy -> ignored.
